// File: rtl/cim_pkg.sv
// Shared constants and state encoding for the CIM MVM command sequencer.
package cim_pkg;

    localparam int CIM_NUM_COLS     = 8;
    localparam int CIM_ROWS_PER_COL = 128;
    localparam int CIM_CHUNK_STRIDE = 8;
    localparam int CIM_DATA_W       = 32;
    localparam int CIM_CNT_W        = 8;
    localparam int CIM_ROW_W        = $clog2(CIM_ROWS_PER_COL);
    localparam int CIM_IDX_W        = $clog2(CIM_NUM_COLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_SETTLE,
        ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/cim_seq_addr_gen.sv
// Chunk counter plus weight row address that wraps inside one column segment.
module cim_seq_addr_gen
    import cim_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CIM_ROW_W-1:0] base,
    input  logic                 step,
    output logic [CIM_ROW_W-1:0] row,
    output logic [CIM_CNT_W-1:0] count
);

    localparam logic [CIM_ROW_W-1:0] STRIDE = CIM_ROW_W'(CIM_CHUNK_STRIDE);

    // The row register is exactly CIM_ROW_W bits wide, so the add wraps modulo the segment size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= '0;
            count <= '0;
        end else if (load) begin
            row   <= base;
            count <= '0;
        end else if (step) begin
            row   <= row + STRIDE;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cim_mvm_sequencer.sv
// Streams one MVM command into the Basic_GeMM_CIM macro and reads back its column sums.
// Define CIM_SEQ_RELU_EN to clamp negative readback values to zero.
module cim_mvm_sequencer
    import cim_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [9:0]            cmd_base_addr,
    input  logic [CIM_CNT_W-1:0]  cmd_num_chunks,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CIM_DATA_W-1:0] in_data,
    output logic                  cim_cs,
    output logic                  cim_write,
    output logic                  cim_en,
    output logic                  cim_partial_sum,
    output logic                  cim_reset_output,
    output logic [3:0]            cim_output_reg,
    output logic [31:0]           cim_address,
    output logic [CIM_DATA_W-1:0] cim_input_data,
    input  logic [CIM_DATA_W-1:0] cim_output,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CIM_DATA_W-1:0] res_data,
    output logic [CIM_IDX_W-1:0]  res_idx,
    output logic                  res_last,
    output logic                  busy
);

    localparam logic [CIM_IDX_W-1:0] LAST_IDX = CIM_IDX_W'(CIM_NUM_COLS - 1);

    seq_state_e           state;
    logic [CIM_CNT_W-1:0] num_chunks;
    logic [CIM_IDX_W-1:0] idx;
    logic [CIM_ROW_W-1:0] row;
    logic [CIM_CNT_W-1:0] chunk_cnt;
    logic                 cmd_hs;
    logic                 in_hs;
    logic                 unused_base_hi;
    logic [CIM_DATA_W-1:0] readback;

    // Only the row-within-segment bits of the base address are meaningful.
    assign unused_base_hi = ^cmd_base_addr[9:CIM_ROW_W];

    assign cmd_hs = (state == ST_IDLE) && cmd_valid;
    assign in_hs  = (state == ST_ACCUM) && in_valid;

    cim_seq_addr_gen u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cmd_hs),
        .base  (cmd_base_addr[CIM_ROW_W-1:0]),
        .step  (in_hs),
        .row   (row),
        .count (chunk_cnt)
    );

    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            num_chunks <= '0;
            idx        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        num_chunks <= cmd_num_chunks;
                        state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR:  state <= (num_chunks != '0) ? ST_ACCUM : ST_SETTLE;
                ST_ACCUM: begin
                    if (in_hs && (chunk_cnt == num_chunks - 1'b1)) state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    idx   <= '0;
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (res_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CIM_SEQ_RELU_EN
    assign readback = cim_output[CIM_DATA_W-1] ? '0 : cim_output;
`else
    assign readback = cim_output;
`endif

    // Macro strobes decode straight from the state register; in ACCUM a bubble drops cs so the macro holds.
    assign cmd_ready        = (state == ST_IDLE);
    assign busy             = (state != ST_IDLE);
    assign in_ready         = (state == ST_ACCUM);
    assign cim_write        = 1'b0;
    assign cim_en           = (state != ST_IDLE);
    assign cim_cs           = (state == ST_CLEAR) || in_hs;
    assign cim_partial_sum  = in_hs;
    assign cim_reset_output = (state == ST_CLEAR);
    assign cim_address      = {25'b0, row};
    assign cim_input_data   = (state == ST_ACCUM) ? in_data : '0;
    assign cim_output_reg   = (state == ST_DRAIN) ? {1'b0, idx} : 4'd0;
    assign res_valid        = (state == ST_DRAIN);
    assign res_data         = (state == ST_DRAIN) ? readback : '0;
    assign res_idx          = (state == ST_DRAIN) ? idx : '0;
    assign res_last         = (state == ST_DRAIN) && (idx == LAST_IDX);

endmodule

// File: tb/tb_cim_mvm_sequencer.sv
// Self-checking bench: behavioural Basic_GeMM_CIM macro plus result/address scoreboards.
module tb_cim_mvm_sequencer;
    import cim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_base_addr;
    logic [7:0]  cmd_num_chunks;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address, cim_input_data, cim_output;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_idx;
    logic        res_last, busy;

    always #5 clk = ~clk;

    cim_mvm_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_base_addr    (cmd_base_addr),
        .cmd_num_chunks   (cmd_num_chunks),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .cim_cs           (cim_cs),
        .cim_write        (cim_write),
        .cim_en           (cim_en),
        .cim_partial_sum  (cim_partial_sum),
        .cim_reset_output (cim_reset_output),
        .cim_output_reg   (cim_output_reg),
        .cim_address      (cim_address),
        .cim_input_data   (cim_input_data),
        .cim_output       (cim_output),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_idx          (res_idx),
        .res_last         (res_last),
        .busy             (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  idx;
        logic        last;
    } res_t;

    logic [7:0]  w [8][128];
    int          acc [8];
    logic [31:0] words [4];
    logic [31:0] addr_q [$];
    res_t        res_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          write_cnt = 0;
    int          in_ready_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int dot(input int c, input int row0, input logic [31:0] d);
        int s = 0;
        for (int e = 0; e < 8; e++)
            s += int'(d[31-4*e -: 4]) * int'(w[c][(row0 + e) % 128]);
        return s;
    endfunction

    // Macro model: clear or accumulate on a selected cycle; readback is acc[13:8] sign-extended.
    always @(posedge clk) begin
        if (cim_cs && cim_en) begin
            for (int c = 0; c < 8; c++) begin
                if (cim_reset_output) acc[c] <= 0;
                else if (cim_partial_sum)
                    acc[c] <= acc[c] + dot(c, int'(cim_address[6:0]), cim_input_data);
            end
        end
    end

    logic [31:0] acc_sel;
    always_comb begin
        acc_sel    = acc[cim_output_reg[2:0]];
        cim_output = {{26{acc_sel[13]}}, acc_sel[13:8]};
    end

    always @(negedge clk) begin
        if (cim_write) write_cnt <= write_cnt + 1;
        if (in_ready) in_ready_cnt <= in_ready_cnt + 1;
        if (cim_cs && cim_partial_sum) begin
            if (addr_q.size() == 0) check("addr_extra", cim_address, 32'hFFFF_FFFF);
            else check("cim_address", cim_address, addr_q.pop_front());
        end
    end

    function automatic logic [31:0] exp_res(input int c, input int base, input int n);
        logic [31:0] a;
        logic [31:0] v;
        a = 0;
        for (int k = 0; k < n; k++) a = a + 32'(dot(c, base + 8 * k, words[k]));
        v = {{26{a[13]}}, a[13:8]};
`ifdef CIM_SEQ_RELU_EN
        if (v[31]) v = 0;
`endif
        return v;
    endfunction

    task automatic set_w1();
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 128; r++) w[c][r] = 8'd0;
        for (int r = 0; r < 8; r++) w[0][r] = 8'd64;
    endtask

    task automatic run_cmd(input int base, input int n, input int gap, input bit toggle);
        for (int c = 0; c < 8; c++) res_q.push_back('{exp_res(c, base, n), 3'(c), c == 7});
        for (int k = 0; k < n; k++) addr_q.push_back({25'b0, 7'(base + 8 * k)});
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base_addr = 10'(base);
        cmd_num_chunks = 8'(n);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        fork
            begin : drive_inputs
                for (int k = 0; k < n; k++) begin
                    bit hs = 0;
                    int guard = 0;
                    repeat (gap) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    in_valid = 1'b1;
                    in_data  = words[k];
                    do begin
                        @(negedge clk);
                        hs = in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!hs && guard < 50);
                    if (!hs) check("in_timeout", 0, 1);
                end
                in_valid = 1'b0;
            end
            begin : drain_results
                int  got = 0;
                int  cyc = 0;
                bit  first = 1;
                res_t r;
                res_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
                while (got < 8 && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                    if (res_valid) begin
                        if (first) begin
                            if (gap == 0) check("latency", cyc, n + 3);
                            first = 0;
                        end
                        if (res_q.size() == 0) begin
                            check("res_extra", res_data, 32'hDEAD_BEEF);
                        end else if (res_ready) begin
                            r = res_q.pop_front();
                            check("res_data", res_data, r.data);
                            check("res_idx", 32'(res_idx), 32'(r.idx));
                            check("res_last", 32'(res_last), 32'(r.last));
                            got++;
                        end else begin
                            check("res_hold", res_data, res_q[0].data);
                        end
                    end
                    @(posedge clk); #1;
                    res_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (got < 8) check("drain_timeout", got, 8);
                res_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("idle_after", busy, 0);
        check("addr_q_empty", addr_q.size(), 0);
    endtask

    initial begin
        int irc;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_base_addr = '0;
        cmd_num_chunks = '0;
        in_valid = 1'b0;
        in_data = '0;
        res_ready = 1'b0;
        for (int c = 0; c < 8; c++) acc[c] = 0;
        for (int k = 0; k < 4; k++) words[k] = 32'hFFFF_FFFF;
        set_w1();

        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_cim_cs", cim_cs, 0);
        check("rst_cim_address", cim_address, 0);
        #2 rst_n = 1'b1;

        // Basic: col0 rows 0-7 at 64, one all-ones chunk -> idx0 = 30.
        run_cmd(0, 1, 0, 0);

        // Wrap: base 120 then row 0; write strobe never asserted.
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 128; r++) w[c][r] = 8'd0;
        for (int r = 120; r < 128; r++) w[1][r] = 8'd100;
        for (int r = 0; r < 8; r++) w[3][r] = 8'd50;
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h1234_5678;
        run_cmd(120, 2, 0, 0);
        check("no_write", write_cnt, 0);

        // Backpressure on both streams, same results as the basic case.
        set_w1();
        for (int k = 0; k < 4; k++) words[k] = 32'hFFFF_FFFF;
        run_cmd(0, 3, 2, 1);

        // Negative readback: accumulator 0x3C00 -> -4 (or 0 with ReLU).
        for (int r = 8; r < 16; r++) w[0][r] = 8'd64;
        run_cmd(0, 2, 0, 1);

        // Zero chunks: accumulators cleared, input stream never opened.
        irc = in_ready_cnt;
        run_cmd(5, 0, 0, 0);
        check("no_in_ready", in_ready_cnt - irc, 0);

        // Reset during ACCUM, then a fresh command.
        set_w1();
        addr_q.push_back(32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base_addr = '0;
        cmd_num_chunks = 8'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_in_ready", in_ready, 0);
        check("arst_addr_q", addr_q.size(), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_cmd(0, 1, 0, 0);
        check("final_no_write", write_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
